// File: rtl/dcm_pkg.sv
// Shared definitions for the DCM start-up / lock-supervision / phase-shift controller.
package dcm_pkg;

  localparam int PS_W = 9;

  localparam int ST_CLKIN_STOP = 1;
  localparam int ST_CLKFX_STOP = 2;

  localparam logic [2:0] S_RST_PULSE = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_PS_WAIT   = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  typedef enum logic [2:0] {
    RST_PULSE = S_RST_PULSE,
    WAIT_LOCK = S_WAIT_LOCK,
    STABLE    = S_STABLE,
    RUN       = S_RUN,
    PS_WAIT   = S_PS_WAIT,
    FAULT     = S_FAULT
  } state_t;

  // Sizes the shared timer so it can reach the longest of the three intervals.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dcm_seq_if.sv
// DCM pin bundle plus the single-requester phase-shift handshake.
interface dcm_seq_if;
  import dcm_pkg::*;

  logic                   dcm_locked;
  logic [7:0]             dcm_status;
  logic                   dcm_psdone;
  logic                   dcm_rst;
  logic                   dcm_psen;
  logic                   dcm_psincdec;
  logic                   ready;
  logic                   fault;
  logic [2:0]             retry_cnt;
  logic                   ps_req;
  logic                   ps_dir;
  logic                   ps_busy;
  logic                   ps_ack;
  logic                   ps_sat;
  logic signed [PS_W-1:0] ps_value;

  modport master (
    input  dcm_locked, dcm_status, dcm_psdone, ps_req, ps_dir,
    output dcm_rst, dcm_psen, dcm_psincdec, ready, fault, retry_cnt,
           ps_busy, ps_ack, ps_sat, ps_value
  );

  modport slave (
    output dcm_locked, dcm_status, dcm_psdone, ps_req, ps_dir,
    input  dcm_rst, dcm_psen, dcm_psincdec, ready, fault, retry_cnt,
           ps_busy, ps_ack, ps_sat, ps_value
  );

endinterface

// File: rtl/dcm_seq_timer.sv
// Saturating up-counter with clear, count enable and a terminal-count flag.
module dcm_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == term);

endmodule

// File: rtl/dcm_seq.sv
// DCM_SP controller: reset sequencing, lock supervision with bounded retries,
// and the PSEN/PSINCDEC/PSDONE phase-shift handshake for one requester.
module dcm_seq
  import dcm_pkg::*;
#(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 7,
  parameter int PS_LIMIT      = 255
) (
  input logic       clk,
  input logic       rst,
  dcm_seq_if.master bus
);

  localparam int TW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

  localparam logic [TW-1:0] RST_TERM    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_TERM   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_TERM = TW'(STABLE_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX   = 3'(MAX_RETRIES);

  localparam logic signed [PS_W:0]   LIM_HI = (PS_W + 1)'(PS_LIMIT);
  localparam logic signed [PS_W:0]   LIM_LO = -LIM_HI;
  localparam logic signed [PS_W:0]   STEP1  = (PS_W + 1)'(1);
  localparam logic signed [PS_W-1:0] PS_ONE = PS_W'(1);

  state_t                 state_q, state_d;
  logic [2:0]             retry_q, retry_d;
  logic signed [PS_W-1:0] ps_value_q, ps_value_d;
  logic                   psen_q, psen_d;
  logic                   dir_q, dir_d;
  logic                   ack_q, ack_d;
  logic                   sat_q, sat_d;

  logic          tmr_clr, tmr_en, tmr_done;
  logic [TW-1:0] tmr_term;
  logic          attempt_failed;
  logic [2:0]    retry_inc;
  logic          loss;
  logic          status_unused;

  logic signed [PS_W:0] ps_ext, ps_target;
  logic                 ps_in_range;

  dcm_seq_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .term (tmr_term),
    .done (tmr_done)
  );

  assign loss          = !bus.dcm_locked | bus.dcm_status[ST_CLKIN_STOP] | bus.dcm_status[ST_CLKFX_STOP];
  assign status_unused = ^{bus.dcm_status[7:3], bus.dcm_status[0]};
  assign retry_inc     = retry_q + 3'd1;

  // Range check is done one bit wider so the +-1 can never wrap.
  assign ps_ext      = {ps_value_q[PS_W-1], ps_value_q};
  assign ps_target   = bus.ps_dir ? (ps_ext + STEP1) : (ps_ext - STEP1);
  assign ps_in_range = (ps_target <= LIM_HI) && (ps_target >= LIM_LO);

  always_comb begin
    state_d        = state_q;
    retry_d        = retry_q;
    ps_value_d     = ps_value_q;
    dir_d          = dir_q;
    psen_d         = 1'b0;
    ack_d          = 1'b0;
    sat_d          = 1'b0;
    tmr_en         = 1'b0;
    tmr_term       = RST_TERM;
    attempt_failed = 1'b0;

    case (state_q)
      RST_PULSE: begin
        tmr_en = 1'b1;
        if (tmr_done) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        tmr_en   = 1'b1;
        tmr_term = LOCK_TERM;
        if (bus.dcm_locked) state_d = STABLE;
        else if (tmr_done)  attempt_failed = 1'b1;
      end
      STABLE: begin
        tmr_en   = 1'b1;
        tmr_term = STABLE_TERM;
        if (!bus.dcm_locked) begin
          attempt_failed = 1'b1;
        end else if (tmr_done) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (loss) begin
          retry_d = '0;
          state_d = RST_PULSE;
        end else if (bus.ps_req) begin
          if (ps_in_range) begin
            psen_d  = 1'b1;
            dir_d   = bus.ps_dir;
            state_d = PS_WAIT;
          end else begin
            ack_d = 1'b1;
            sat_d = 1'b1;
          end
        end
      end
      PS_WAIT: begin
        // A loss abandons the outstanding step silently, even if PSDONE coincides.
        if (loss) begin
          retry_d = '0;
          state_d = RST_PULSE;
        end else if (bus.dcm_psdone) begin
          ps_value_d = dir_q ? (ps_value_q + PS_ONE) : (ps_value_q - PS_ONE);
          ack_d      = 1'b1;
          state_d    = RUN;
        end
      end
      FAULT: begin
      end
      default: state_d = RST_PULSE;
    endcase

    if (attempt_failed) begin
      retry_d = retry_inc;
      state_d = (retry_inc == RETRY_MAX) ? FAULT : RST_PULSE;
    end

    // A DCM reset returns the phase to zero.
    if ((state_d == RST_PULSE) && (state_q != RST_PULSE)) ps_value_d = '0;
  end

  assign tmr_clr = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_PULSE;
      retry_q    <= '0;
      ps_value_q <= '0;
      psen_q     <= 1'b0;
      dir_q      <= 1'b0;
      ack_q      <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      ps_value_q <= ps_value_d;
      psen_q     <= psen_d;
      dir_q      <= dir_d;
      ack_q      <= ack_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.dcm_rst      = (state_q == RST_PULSE) || (state_q == FAULT);
  assign bus.dcm_psen     = psen_q;
  assign bus.dcm_psincdec = psen_q & dir_q;
  assign bus.ready        = (state_q == RUN) || (state_q == PS_WAIT);
  assign bus.fault        = (state_q == FAULT);
  assign bus.retry_cnt    = retry_q;
  assign bus.ps_busy      = (state_q == PS_WAIT);
  assign bus.ps_ack       = ack_q;
  assign bus.ps_sat       = sat_q;
  assign bus.ps_value     = ps_value_q;

endmodule

// File: tb/tb_dcm_seq.sv
// Bench for dcm_seq: lock sequencing, loss recovery, retry exhaustion and phase stepping.
module tb_dcm_seq;
  import dcm_pkg::*;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 300;
  localparam int STABLE_CYCLES = 256;
  localparam int MAX_RETRIES   = 7;
  localparam int PS_LIMIT      = 255;

  typedef struct packed {
    logic                   sat;
    logic signed [PS_W-1:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   ps_model = 0;
  bit   psdone_auto = 1'b1;
  int   psd_cnt = 0;
  int   psen_seen = 0;

  dcm_seq_if bus();

  dcm_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .PS_LIMIT     (PS_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // DCM model: PSDONE pulses three cycles after each PSEN.
  always @(negedge clk) begin
    bus.dcm_psdone = 1'b0;
    if (!psdone_auto) begin
      psd_cnt = 0;
    end else begin
      if (psd_cnt > 0) begin
        psd_cnt--;
        if (psd_cnt == 0) bus.dcm_psdone = 1'b1;
      end
      if (bus.dcm_psen === 1'b1) psd_cnt = 3;
    end
  end

  always @(negedge clk) if (bus.dcm_psen === 1'b1) psen_seen++;

  // Scoreboard: every ack must match the oldest outstanding expected result.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ps_ack === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got ack with sat=%0b value=%0d, required no ack", bus.ps_sat, bus.ps_value);
      end else begin
        e = exp_q.pop_front();
        if ({bus.ps_sat, bus.ps_value} !== e) begin
          errors++;
          $display("FAIL ack_result: got sat=%0b value=%0d, required sat=%0b value=%0d",
                   bus.ps_sat, bus.ps_value, e.sat, e.value);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic count_while(input logic level, input int bound, output int n);
    n = 0;
    while (bus.dcm_rst === level && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic lock_and_wait(output int n);
    bus.dcm_locked = 1'b1;
    @(negedge clk);
    n = 0;
    while (bus.ready !== 1'b1 && n < 2 * STABLE_CYCLES) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_step(input logic dir);
    int   target, pulses;
    bit   got, exp_sat;
    exp_t e;
    target  = ps_model + (dir ? 1 : -1);
    exp_sat = (target > PS_LIMIT) || (target < -PS_LIMIT);
    if (!exp_sat) ps_model = target;
    e.sat   = exp_sat;
    e.value = PS_W'(ps_model);
    exp_q.push_back(e);
    bus.ps_req = 1'b1;
    bus.ps_dir = dir;
    pulses = 0;
    got    = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (bus.dcm_psen === 1'b1) begin
        pulses++;
        checks++;
        if (bus.dcm_psincdec !== dir) begin
          errors++;
          $display("FAIL psincdec: got %0b, required %0b", bus.dcm_psincdec, dir);
        end
      end
      if (bus.ps_ack === 1'b1) got = 1'b1;
    end
    bus.ps_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL step_ack_timeout: got no ps_ack within 40 cycles, required one");
    end
    checks++;
    if (pulses != (exp_sat ? 0 : 1)) begin
      errors++;
      $display("FAIL psen_pulses: got %0d cycles of dcm_psen, required %0d", pulses, exp_sat ? 0 : 1);
    end
    $display("step dir=%0b sat=%0b ps_value=%0d psen_cycles=%0d", dir, bus.ps_sat, bus.ps_value, pulses);
  endtask

  task automatic test_reset;
    logic [19:0] obs, want;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs  = {bus.dcm_rst, bus.dcm_psen, bus.dcm_psincdec, bus.ready, bus.fault, bus.retry_cnt,
            bus.ps_busy, bus.ps_ack, bus.ps_sat, bus.ps_value};
    want = {1'b1, 19'd0};
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL reset_values: got %b, required %b", obs, want);
    end
    $display("reset outputs=%b", obs);
  endtask

  task automatic test_lock_startup;
    int n;
    rst = 1'b0;
    count_while(1'b1, 20, n);
    checks++;
    if (n != RST_CYCLES) begin
      errors++;
      $display("FAIL startup_rst_width: got %0d, required %0d", n, RST_CYCLES);
    end
    repeat (100) @(negedge clk);
    checks++;
    if ({bus.dcm_rst, bus.ready} !== 2'b00) begin
      errors++;
      $display("FAIL wait_lock_outputs: got dcm_rst,ready=%b, required 00", {bus.dcm_rst, bus.ready});
    end
    lock_and_wait(n);
    checks++;
    if (n != STABLE_CYCLES) begin
      errors++;
      $display("FAIL lock_to_ready: got %0d cycles, required %0d", n, STABLE_CYCLES);
    end
    checks++;
    if (bus.retry_cnt !== 3'd0) begin
      errors++;
      $display("FAIL startup_retry: got %0d, required 0", bus.retry_cnt);
    end
    $display("startup rst_width=%0d lock_to_ready=%0d retry=%0d", RST_CYCLES, n, bus.retry_cnt);
  endtask

  task automatic test_status_loss;
    int   bits[2] = '{ST_CLKIN_STOP, ST_CLKFX_STOP};
    int   n;
    logic [7:0] st;
    for (int i = 0; i < 2; i++) begin
      st = 8'd0;
      st[bits[i]] = 1'b1;
      bus.dcm_status = st;
      bus.dcm_locked = 1'b0;
      @(negedge clk);
      bus.dcm_status = 8'd0;
      checks++;
      if ({bus.ready, bus.dcm_rst} !== 2'b01) begin
        errors++;
        $display("FAIL loss_response: got ready,dcm_rst=%b, required 01", {bus.ready, bus.dcm_rst});
      end
      count_while(1'b1, 20, n);
      checks++;
      if (n != RST_CYCLES) begin
        errors++;
        $display("FAIL loss_rst_width: got %0d, required %0d", n, RST_CYCLES);
      end
      checks++;
      if (bus.retry_cnt !== 3'd0) begin
        errors++;
        $display("FAIL loss_retry: got %0d, required 0", bus.retry_cnt);
      end
      repeat (20) @(negedge clk);
      lock_and_wait(n);
      checks++;
      if (n != STABLE_CYCLES) begin
        errors++;
        $display("FAIL relock_to_ready: got %0d cycles, required %0d", n, STABLE_CYCLES);
      end
      $display("status bit %0d loss: relocked, ready after %0d cycles", bits[i], n);
    end
  endtask

  task automatic test_ps_inc;
    for (int i = 0; i < 10; i++) do_step(1'b1);
    @(negedge clk);
    checks++;
    if (bus.ps_value !== 9'sd10 || bus.ps_busy !== 1'b0) begin
      errors++;
      $display("FAIL ps_inc_final: got value=%0d busy=%0b, required value=10 busy=0", bus.ps_value, bus.ps_busy);
    end
  endtask

  task automatic test_ps_sat;
    for (int i = 0; i < 265; i++) do_step(1'b0);
    checks++;
    if (bus.ps_value !== -9'sd255) begin
      errors++;
      $display("FAIL ps_at_limit: got %0d, required -255", bus.ps_value);
    end
    do_step(1'b0);
    @(negedge clk);
    checks++;
    if (bus.ps_value !== -9'sd255) begin
      errors++;
      $display("FAIL ps_sat_unchanged: got %0d, required -255", bus.ps_value);
    end
    do_step(1'b1);
    do_step(1'b0);
  endtask

  task automatic test_ps_loss;
    int n, snap;
    bit busy;
    psdone_auto = 1'b0;
    bus.ps_req  = 1'b1;
    bus.ps_dir  = 1'b1;
    busy = 1'b0;
    for (int c = 0; c < 10 && !busy; c++) begin
      @(negedge clk);
      busy = (bus.ps_busy === 1'b1);
    end
    checks++;
    if (!busy) begin
      errors++;
      $display("FAIL ps_loss_busy: got ps_busy=0 after request, required 1");
    end
    bus.dcm_locked = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ps_busy, bus.ps_ack, bus.ready, bus.dcm_rst} !== 4'b0001) begin
      errors++;
      $display("FAIL ps_loss_response: got busy,ack,ready,dcm_rst=%b, required 0001",
               {bus.ps_busy, bus.ps_ack, bus.ready, bus.dcm_rst});
    end
    snap = psen_seen;
    count_while(1'b1, 20, n);
    repeat (10) @(negedge clk);
    bus.ps_req = 1'b0;
    lock_and_wait(n);
    ps_model = 0;
    checks++;
    if (psen_seen != snap) begin
      errors++;
      $display("FAIL ps_req_ignored: got %0d psen pulses outside RUN, required 0", psen_seen - snap);
    end
    checks++;
    if (bus.ps_value !== 9'sd0 || n != STABLE_CYCLES) begin
      errors++;
      $display("FAIL ps_loss_relock: got value=%0d lock_to_ready=%0d, required value=0 lock_to_ready=%0d",
               bus.ps_value, n, STABLE_CYCLES);
    end
    $display("ps loss: step abandoned, relocked, ps_value=%0d", bus.ps_value);
    psdone_auto = 1'b1;
    do_step(1'b0);
  endtask

  task automatic test_timeout_fault;
    int n;
    bus.dcm_locked = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= MAX_RETRIES; k++) begin
      count_while(1'b1, 20, n);
      checks++;
      if (n != RST_CYCLES) begin
        errors++;
        $display("FAIL retry_pulse_%0d: got width %0d, required %0d", k, n, RST_CYCLES);
      end
      count_while(1'b0, LOCK_TIMEOUT + 10, n);
      checks++;
      if (n != LOCK_TIMEOUT) begin
        errors++;
        $display("FAIL retry_gap_%0d: got %0d, required %0d", k, n, LOCK_TIMEOUT);
      end
      checks++;
      if (bus.retry_cnt !== 3'(k)) begin
        errors++;
        $display("FAIL retry_count_%0d: got %0d, required %0d", k, bus.retry_cnt, k);
      end
      $display("retry %0d: dcm_rst pulse then %0d cycles without lock", k, n);
    end
    repeat (50) @(negedge clk);
    checks++;
    if ({bus.fault, bus.dcm_rst, bus.ready, bus.retry_cnt} !== 6'b110111) begin
      errors++;
      $display("FAIL fault_hold: got fault,dcm_rst,ready,retry=%b, required 110111",
               {bus.fault, bus.dcm_rst, bus.ready, bus.retry_cnt});
    end
  endtask

  initial begin
    bus.dcm_locked = 1'b0;
    bus.dcm_status = 8'd0;
    bus.ps_req     = 1'b0;
    bus.ps_dir     = 1'b0;
    test_reset();
    test_lock_startup();
    test_status_loss();
    test_ps_inc();
    test_ps_sat();
    test_ps_loss();
    test_timeout_fault();
    test_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding acks, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
